aes_round_ctrl: RTL and testbench

AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

---
 rtl/aes_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_aes_round_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: synchronizes the SPI load strobe, then steps the datapath
// through key expansion, initial key add, the main rounds and the final round.
module aes_round_ctrl #(
    parameter int K = 128
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] dirByte,
    output logic       done,
    output logic       err,
    output logic       inv,
    output logic       ld_state,
    output logic       round_en,
    output logic       last_round,
    output logic       keyexp_en,
    output logic [3:0] round
);

    localparam logic [3:0] NR = (K == 256) ? 4'd14 : (K == 192) ? 4'd12 : 4'd10;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] KEYEXP = 3'd1;
    localparam logic [2:0] INIT   = 3'd2;
    localparam logic [2:0] ROUND  = 3'd3;
    localparam logic [2:0] FINAL  = 3'd4;
    localparam logic [2:0] DONE   = 3'd5;

    logic       loadMeta_q, loadSync_q, loadDly_q;
    logic       start, abort;
    logic [2:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       dir_q, dir_d;
    logic       bad_q, bad_d;

    logic       done_d, err_d, inv_d, ldState_d, roundEn_d, lastRound_d, keyexpEn_d;
    logic [3:0] round_d;

    // Falling edge of the synchronized load starts an operation, rising edge aborts it.
    always_ff @(posedge clk) begin
        if (reset) begin
            loadMeta_q <= 1'b0;
            loadSync_q <= 1'b0;
            loadDly_q  <= 1'b0;
        end else begin
            loadMeta_q <= load;
            loadSync_q <= loadMeta_q;
            loadDly_q  <= loadSync_q;
        end
    end

    assign start = loadDly_q & ~loadSync_q;
    assign abort = loadSync_q & ~loadDly_q;

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        bad_d   = bad_q;
        cnt_d   = 4'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dir_d = dirByte[0];
                    bad_d = (dirByte[7:1] != 7'd0);
                    if (dirByte[7:1] != 7'd0) state_d = DONE;
                    else if (dirByte[0])      state_d = KEYEXP;
                    else                      state_d = INIT;
                end
            end
            KEYEXP:  if (cnt_q == NR - 4'd1) state_d = INIT;
            INIT:    state_d = ROUND;
            ROUND:   if (cnt_q == NR - 4'd2) state_d = FINAL;
            FINAL:   state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q != IDLE) state_d = IDLE;
        // The counter restarts on every state entry, so it never exceeds NR-1.
        if (state_d == state_q && (state_q == KEYEXP || state_q == ROUND))
            cnt_d = cnt_q + 4'd1;
    end

    // Outputs are decoded from the next state so they are registered with it.
    always_comb begin
        done_d      = 1'b0;
        err_d       = 1'b0;
        inv_d       = (state_d != IDLE) & dir_d;
        ldState_d   = 1'b0;
        roundEn_d   = 1'b0;
        lastRound_d = 1'b0;
        keyexpEn_d  = 1'b0;
        round_d     = 4'd0;
        case (state_d)
            KEYEXP: begin
                keyexpEn_d = 1'b1;
                round_d    = cnt_d + 4'd1;
            end
            INIT: begin
                ldState_d = 1'b1;
                round_d   = dir_d ? NR : 4'd0;
            end
            ROUND: begin
                roundEn_d  = 1'b1;
                keyexpEn_d = ~dir_d;
                round_d    = dir_d ? (NR - 4'd1 - cnt_d) : (cnt_d + 4'd1);
            end
            FINAL: begin
                roundEn_d   = 1'b1;
                lastRound_d = 1'b1;
                keyexpEn_d  = ~dir_d;
                round_d     = dir_d ? 4'd0 : NR;
            end
            DONE: begin
                done_d = 1'b1;
                err_d  = bad_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            dir_q      <= 1'b0;
            bad_q      <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            inv        <= 1'b0;
            ld_state   <= 1'b0;
            round_en   <= 1'b0;
            last_round <= 1'b0;
            keyexp_en  <= 1'b0;
            round      <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dir_q      <= dir_d;
            bad_q      <= bad_d;
            done       <= done_d;
            err        <= err_d;
            inv        <= inv_d;
            ld_state   <= ldState_d;
            round_en   <= roundEn_d;
            last_round <= lastRound_d;
            keyexp_en  <= keyexpEn_d;
            round      <= round_d;
        end
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl: three key sizes run side by side against
// a cycle-indexed reference model, plus abort and reset corner sequences.
module tb_aes_round_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       load = 1'b0;
    logic [7:0] dirByte = 8'h00;

    // Observed outputs packed as {done, err, inv, ld_state, round_en, last_round, keyexp_en, round}
    logic [10:0] o0, o1, o2;

    int checks = 0;
    int errors = 0;
    int firstDone [3];
    logic [10:0] lastObs [3];
    int nrOf [3] = '{10, 12, 14};

    typedef struct {
        logic [7:0] dir;
        int         doneAt0;
        int         doneAt1;
        int         doneAt2;
        logic       expErr;
        logic       expInv;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    aes_round_ctrl #(.K(128)) dut128 (
        .clk(clk), .reset(reset), .load(load), .dirByte(dirByte),
        .done(o0[10]), .err(o0[9]), .inv(o0[8]), .ld_state(o0[7]), .round_en(o0[6]),
        .last_round(o0[5]), .keyexp_en(o0[4]), .round(o0[3:0])
    );

    aes_round_ctrl #(.K(192)) dut192 (
        .clk(clk), .reset(reset), .load(load), .dirByte(dirByte),
        .done(o1[10]), .err(o1[9]), .inv(o1[8]), .ld_state(o1[7]), .round_en(o1[6]),
        .last_round(o1[5]), .keyexp_en(o1[4]), .round(o1[3:0])
    );

    aes_round_ctrl #(.K(256)) dut256 (
        .clk(clk), .reset(reset), .load(load), .dirByte(dirByte),
        .done(o2[10]), .err(o2[9]), .inv(o2[8]), .ld_state(o2[7]), .round_en(o2[6]),
        .last_round(o2[5]), .keyexp_en(o2[4]), .round(o2[3:0])
    );

    function automatic logic [10:0] getObs(input int g);
        case (g)
            0:       return o0;
            1:       return o1;
            default: return o2;
        endcase
    endfunction

    // Expected outputs for cycle c after leaving IDLE, straight from the round schedule.
    function automatic logic [10:0] model(input int nr, input logic [7:0] d, input int c);
        logic dn, er, iv, ld, re, lr, ke;
        int   rnd;
        dn = 0; er = 0; iv = d[0]; ld = 0; re = 0; lr = 0; ke = 0; rnd = 0;
        if (d > 8'h01) begin
            dn = 1; er = 1;
        end else if (d == 8'h00) begin
            if (c == 0)           begin ld = 1; rnd = 0; end
            else if (c < nr)      begin re = 1; ke = 1; rnd = c; end
            else if (c == nr)     begin re = 1; ke = 1; lr = 1; rnd = nr; end
            else                  dn = 1;
        end else begin
            if (c < nr)           begin ke = 1; rnd = c + 1; end
            else if (c == nr)     begin ld = 1; rnd = nr; end
            else if (c < 2 * nr)  begin re = 1; rnd = 2 * nr - c; end
            else if (c == 2 * nr) begin re = 1; lr = 1; rnd = 0; end
            else                  dn = 1;
        end
        return {dn, er, iv, ld, re, lr, ke, 4'(rnd)};
    endfunction

    task automatic checkOutput(input string name, input int g, input int cyc,
                               input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, g, cyc, act, exp);
        end
    endtask

    task automatic checkAllIdle(input string name, input int cyc);
        for (int g = 0; g < 3; g++) checkOutput(name, g, cyc, 32'(getObs(g)), 32'd0);
    endtask

    // Raise load (aborting any finished op), then drop it and follow cycles 0..lastCycle.
    task automatic applyStimulus(input logic [7:0] d, input bit scramble, input int lastCycle);
        load = 1'b1;
        repeat (5) @(negedge clk);
        checkAllIdle("idleBeforeStart", -1);
        dirByte = d;
        load = 1'b0;
        for (int g = 0; g < 3; g++) firstDone[g] = -1;
        repeat (2) begin
            @(negedge clk);
            checkAllIdle("startLatency", -1);
        end
        for (int c = 0; c <= lastCycle; c++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
                lastObs[g] = getObs(g);
                checkOutput("trace", g, c, 32'(lastObs[g]), 32'(model(nrOf[g], d, c)));
                if (firstDone[g] < 0 && lastObs[g][10]) firstDone[g] = c;
            end
            if (scramble) dirByte = 8'($urandom);
        end
    endtask

    initial begin
        vecs[0] = '{8'h00, 11, 13, 15, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 21, 25, 29, 1'b0, 1'b1};
        vecs[2] = '{8'h5A,  0,  0,  0, 1'b1, 1'b0};
        vecs[3] = '{8'hFF,  0,  0,  0, 1'b1, 1'b1};

        repeat (3) @(negedge clk);
        checkAllIdle("resetState", -1);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkAllIdle("idleAfterReset", -1);

        $display("[TB] table vectors");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].dir, 1'b0, 31);
            checkOutput("doneAt", 0, i, 32'(firstDone[0]), 32'(vecs[i].doneAt0));
            checkOutput("doneAt", 1, i, 32'(firstDone[1]), 32'(vecs[i].doneAt1));
            checkOutput("doneAt", 2, i, 32'(firstDone[2]), 32'(vecs[i].doneAt2));
            for (int g = 0; g < 3; g++) begin
                checkOutput("finalErr", g, i, 32'(lastObs[g][9]), 32'(vecs[i].expErr));
                checkOutput("finalInv", g, i, 32'(lastObs[g][8]), 32'(vecs[i].expInv));
            end
        end

        $display("[TB] random operations");
        for (int i = 0; i < 10; i++) begin
            logic [7:0] d;
            case ($urandom_range(0, 3))
                0:       d = 8'h00;
                1:       d = 8'h01;
                default: d = 8'($urandom);
            endcase
            applyStimulus(d, 1'b1, 31);
        end

        $display("[TB] abort mid-encrypt");
        applyStimulus(8'h00, 1'b0, 5);
        load = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            for (int g = 0; g < 3; g++) checkOutput("abortNoDone", g, 5 + k, 32'(getObs(g)[10]), 32'd0);
        end
        checkAllIdle("abortIdle", 9);
        applyStimulus(8'h00, 1'b0, 31);

        $display("[TB] reset mid-decrypt");
        applyStimulus(8'h01, 1'b0, 7);
        reset = 1'b1;
        @(negedge clk);
        checkAllIdle("resetMidOp", 8);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkAllIdle("noStartAfterReset", 9 + k);
        end
        applyStimulus(8'h01, 1'b0, 31);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
